// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: sequences MUL through the shared Mult array and DIV through a signed restoring divider into HI/LO.
// Define MDU_DIV_EN to build the divider; without it a DIV completes at once with dz set.
module mdu_seq_ctrl #(
  parameter int MULT_WAIT = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_res1,
  input  logic [63:0] mult_res2,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dz
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MWAIT = 3'd1;
  localparam logic [2:0] DITER = 3'd2;
  localparam logic [2:0] DFIX  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;
  logic        accept;
  logic [63:0] prod;
`ifdef MDU_DIV_EN
  logic [31:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [32:0] diff;
  logic        ge;
`endif
  always_comb begin
    accept  = start && (state_q == IDLE || state_q == DONE);
    prod    = (mult_res1 << 1) + mult_res2;
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
`ifdef MDU_DIV_EN
    diff    = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
    ge      = !diff[32];
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
`endif
    if (accept) begin
      dz_d = 1'b0;
      if (!op) begin
        ma_d    = a;
        mb_d    = b;
        cnt_d   = 5'd0;
        state_d = MWAIT;
`ifdef MDU_DIV_EN
      end else if (b != 32'd0) begin
        dvd_d   = a[31] ? -a : a;
        dvs_d   = b[31] ? -b : b;
        rem_d   = 32'd0;
        sa_d    = a[31];
        sb_d    = b[31];
        cnt_d   = 5'd0;
        state_d = DITER;
`endif
      end else begin
        hi_d    = a;
        lo_d    = 32'hFFFF_FFFF;
        dz_d    = 1'b1;
        state_d = DONE;
      end
    end else if (state_q == MWAIT) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'(MULT_WAIT - 1)) begin
        {hi_d, lo_d} = prod;
        state_d      = DONE;
      end
`ifdef MDU_DIV_EN
    end else if (state_q == DITER) begin
      rem_d   = ge ? diff[31:0] : {rem_q[30:0], dvd_q[31]};
      dvd_d   = {dvd_q[30:0], ge};
      cnt_d   = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? DFIX : DITER;
    end else if (state_q == DFIX) begin
      lo_d    = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
      hi_d    = sa_q ? -rem_q : rem_q;
      state_d = DONE;
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
`ifdef MDU_DIV_EN
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
`ifdef MDU_DIV_EN
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end
  assign mult_a = ma_q;
  assign mult_b = mb_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign dz     = dz_q;
  assign done   = state_q == DONE;
  assign busy   = state_q != IDLE && state_q != DONE;
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: vector table plus scoreboard for mdu_seq_ctrl; expectations follow MDU_DIV_EN.
module tb_mdu_seq_ctrl;
  localparam int MW = 2;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef struct {
    logic        op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;
  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
    int          at;
  } sb_t;
  logic        clk = 1'b0, clr = 1'b0, start = 1'b0, op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] mult_a, mult_b, hi, lo;
  logic [63:0] mult_res1, mult_res2, p;
  logic        busy, done, dz;
  int          checks = 0, errors = 0, edge_n = 0;
  sb_t         sb[$];
  vec_t        tbl[14];
  mdu_seq_ctrl #(.MULT_WAIT(MW)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_res1(mult_res1), .mult_res2(mult_res2),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;
  // Mult array model: the product is split unevenly so the <<1 recombination matters
  always_comb begin
    p         = {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};
    mult_res1 = {mult_b, mult_a} ^ 64'h0123_4567_89AB_CDEF;
    mult_res2 = p - (mult_res1 << 1);
  end
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction
  function automatic vec_t ml(input logic [31:0] x, input logic [31:0] y, input logic [63:0] pr);
    return '{1'b0, x, y, pr[63:32], pr[31:0], 1'b0, MW + 1};
  endfunction
  function automatic vec_t dv(input logic [31:0] x, input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    if (!DIV_EN || y == 32'd0) return '{1'b1, x, y, x, 32'hFFFF_FFFF, 1'b1, 1};
    return '{1'b1, x, y, eh, el, 1'b0, 34};
  endfunction
  always @(negedge clk) begin
    sb_t e;
    if (done) begin
      if (sb.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
      else begin
        e = sb.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("dz", 64'(dz), 64'(e.dz));
        chk("done_edge", 64'(edge_n), 64'(e.at));
      end
    end
  end
  task automatic drive(input logic o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed, input int lat, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) sb.push_back('{eh, el, ed, edge_n + lat});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    if (sb.size() != 0) sb.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = ml(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    tbl[1]  = dv(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tbl[2]  = dv(32'd100, 32'd7, 32'd2, 32'd14);
    tbl[3]  = dv(32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    tbl[4]  = ml(32'd3, 32'd4, 64'd12);
    tbl[5]  = dv(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    tbl[6]  = ml(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    tbl[7]  = ml(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    tbl[8]  = dv(32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    tbl[9]  = dv(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);
    tbl[10] = ml(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    tbl[11] = dv(32'd5, 32'hFFFF_FFF6, 32'd5, 32'd0);
    tbl[12] = ml(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    tbl[13] = dv(32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000);
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_mult", {mult_a, mult_b}, 64'd0);
    chk("rst_flags", 64'({busy, done, dz}), 64'd0);
    clr = 1'b1;
    @(negedge clk);
    foreach (tbl[k]) begin
      for (int i = 0; i < 60 && busy; i++) @(negedge clk);
      drive(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].hi, tbl[k].lo, tbl[k].dz, tbl[k].lat, 1'b1);
      chk("busy_c1", 64'(busy), 64'(tbl[k].lat > 1));
      drain();
      if (!tbl[k].op) chk("mult_ops", {mult_a, mult_b}, {tbl[k].a, tbl[k].b});
    end
    // start while busy is dropped; start in the DONE cycle is taken back-to-back
    @(negedge clk);
    drive(1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, MW + 1, 1'b1);
    chk("busy_c1_seq", 64'(busy), 64'd1);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy_c2_seq", 64'(busy), 64'd1);
    chk("ops_held", {mult_a, mult_b}, {32'd5, 32'd6});
    @(negedge clk);
    chk("done_c3", 64'(done), 64'd1);
    chk("busy_c3", 64'(busy), 64'd0);
    drive(1'b0, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, MW + 1, 1'b1);
    chk("busy_b2b", 64'(busy), 64'd1);
    drain();
    // async clear in the middle of a divide discards it
    @(negedge clk);
    drive(1'b1, 32'd1000, 32'd3, 32'd1000, 32'hFFFF_FFFF, 1'b1, 1, !DIV_EN);
    repeat (9) @(negedge clk);
    chk("busy_step10", 64'(busy), 64'(DIV_EN));
    chk("hilo_before_clr", 64'({hi, lo} != 64'd0), 64'd1);
    #2 clr = 1'b0;
    #1;
    chk("clr_hilo", {hi, lo}, 64'd0);
    chk("clr_mult", {mult_a, mult_b}, 64'd0);
    chk("clr_flags", 64'({busy, done, dz}), 64'd0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    drive(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, MW + 1, 1'b1);
    drain();
    repeat (40) @(negedge clk);
    chk("idle_end", 64'({busy, done}), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
